// File: rtl/p16_add_pipe_shell.sv
// p16_add_pipe_shell: valid/ready pipeline shell around a 16-bit sparse-4
// Ling adder (P16_node_adder).
// Datapath: skid (SK) -> stage 1 (S1) -> adder -> output register (OR).
// Optional feature macro: P16_FLAGS_EN adds registered out_cout/out_ovf/out_zero.
//
// Handshake: a transfer happens on a cycle where valid & ready are both high
// at the rising edge. A producer holding valid may not change its payload
// until ready is seen; out_* hold while out_valid & !out_ready.

// Combinational 16-bit sparse-4 Ling adder. Ling pseudo-carries are formed
// only at group boundaries (bits 3, 7, 11); each 4-bit group is a
// carry-select pair picked by the real carry t[j-1] & H[j-1].
module P16_node_adder (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);

  logic [15:0] g;
  logic [15:0] t;
  logic [15:0] p;
  logic [2:0]  grp_g;
  logic [2:1]  grp_t;
  logic [2:0]  h;
  logic [3:0]  cin;
  logic [3:0]  s_c0 [4];
  logic [3:0]  s_c1 [4];

  // Ripple sum of one 4-bit group for a fixed carry-in.
  function automatic logic [3:0] grp_sum(input logic [3:0] gg, input logic [3:0] tt,
                                         input logic [3:0] pp, input logic c0);
    logic       c;
    logic [3:0] s;
    c = c0;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = pp[i] ^ c;
      c    = gg[i] | (tt[i] & c);
    end
    return s;
  endfunction

  // Group Ling generate/transmit, boundary pseudo-carries and carry-select sums.
  always_comb begin
    g = a_i & b_i;
    t = a_i | b_i;
    p = a_i ^ b_i;

    // Group Ling generate: H[j+3] with H[j-1] = 0.
    grp_g[0] = g[3]  | g[2]  | (t[2]  & g[1]) | (t[2]  & t[1]  & g[0]);
    grp_g[1] = g[7]  | g[6]  | (t[6]  & g[5]) | (t[6]  & t[5]  & g[4]);
    grp_g[2] = g[11] | g[10] | (t[10] & g[9]) | (t[10] & t[9]  & g[8]);
    // Group Ling transmit spans bits j-1 .. j+2.
    grp_t[1] = t[6]  & t[5]  & t[4]  & t[3];
    grp_t[2] = t[10] & t[9]  & t[8]  & t[7];

    // Prefix combine of the pseudo-carries at bits 3, 7, 11.
    h[0] = grp_g[0];
    h[1] = grp_g[1] | (grp_t[1] & grp_g[0]);
    h[2] = grp_g[2] | (grp_t[2] & grp_g[1]) | (grp_t[2] & grp_t[1] & grp_g[0]);

    // Real carry into each group: c[j-1] = t[j-1] & H[j-1].
    cin[0] = 1'b0;
    cin[1] = t[3]  & h[0];
    cin[2] = t[7]  & h[1];
    cin[3] = t[11] & h[2];

    sum_o = '0;
    for (int k = 0; k < 4; k++) begin
      s_c0[k] = grp_sum(g[4*k +: 4], t[4*k +: 4], p[4*k +: 4], 1'b0);
      s_c1[k] = grp_sum(g[4*k +: 4], t[4*k +: 4], p[4*k +: 4], 1'b1);
      sum_o[4*k +: 4] = cin[k] ? s_c1[k] : s_c0[k];
    end
  end

endmodule

module p16_add_pipe_shell #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] op_count
`ifdef P16_FLAGS_EN
  ,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
`endif
);

  // Skid entry
  logic             sk_valid_q, sk_valid_d;
  logic [15:0]      sk_a_q, sk_a_d;
  logic [15:0]      sk_b_q, sk_b_d;
  logic [TAG_W-1:0] sk_tag_q, sk_tag_d;
  // Stage 1 (adder operands)
  logic             s1_valid_q, s1_valid_d;
  logic [15:0]      s1_a_q, s1_a_d;
  logic [15:0]      s1_b_q, s1_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  // Output register
  logic             or_valid_q, or_valid_d;
  logic [15:0]      or_sum_q, or_sum_d;
  logic [TAG_W-1:0] or_tag_q, or_tag_d;
  // Control
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        in_fire;
  logic        out_fire;
  logic        or_free;
  logic        s1_move;
  logic        s1_free;
  logic [15:0] add_sum;

  P16_node_adder u_adder (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .sum_o (add_sum)
  );

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = or_valid_q & out_ready;
  assign or_free  = ~or_valid_q | out_ready;
  assign s1_move  = s1_valid_q & or_free;
  assign s1_free  = ~s1_valid_q | s1_move;

  // Next-state for skid, stage 1, output register, in_ready and counter.
  always_comb begin
    sk_valid_d = sk_valid_q;
    sk_a_d     = sk_a_q;
    sk_b_d     = sk_b_q;
    sk_tag_d   = sk_tag_q;
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    or_valid_d = or_valid_q;
    or_sum_d   = or_sum_q;
    or_tag_d   = or_tag_q;
    cnt_d      = cnt_q + CNT_W'(out_fire);

    // OR takes the adder result whenever S1 can move; a drained OR empties.
    if (s1_move) begin
      or_valid_d = 1'b1;
      or_sum_d   = add_sum;
      or_tag_d   = s1_tag_q;
    end else if (out_fire) begin
      or_valid_d = 1'b0;
    end

    // S1 refills from SK first so the older entry keeps its place in order.
    if (s1_free) begin
      if (sk_valid_q) begin
        s1_valid_d = 1'b1;
        s1_a_d     = sk_a_q;
        s1_b_d     = sk_b_q;
        s1_tag_d   = sk_tag_q;
        sk_valid_d = 1'b0;
      end else if (in_fire) begin
        s1_valid_d = 1'b1;
        s1_a_d     = in_a;
        s1_b_d     = in_b;
        s1_tag_d   = in_tag;
      end else begin
        s1_valid_d = 1'b0;
      end
    end

    // An accepted op that S1 cannot take parks in SK; in_ready was high,
    // so SK is known to be empty here.
    if (in_fire && !s1_free) begin
      sk_valid_d = 1'b1;
      sk_a_d     = in_a;
      sk_b_d     = in_b;
      sk_tag_d   = in_tag;
    end

    in_ready_d = ~sk_valid_d;
  end

  // Pipeline state registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_valid_q <= 1'b0;
      sk_a_q     <= '0;
      sk_b_q     <= '0;
      sk_tag_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      or_valid_q <= 1'b0;
      or_sum_q   <= '0;
      or_tag_q   <= '0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sk_valid_q <= sk_valid_d;
      sk_a_q     <= sk_a_d;
      sk_b_q     <= sk_b_d;
      sk_tag_q   <= sk_tag_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      or_valid_q <= or_valid_d;
      or_sum_q   <= or_sum_d;
      or_tag_q   <= or_tag_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = or_valid_q;
  assign out_sum   = or_sum_q;
  assign out_tag   = or_tag_q;
  assign op_count  = cnt_q;

`ifdef P16_FLAGS_EN
  logic or_cout_q, or_ovf_q, or_zero_q;
  logic flg_cout, flg_ovf, flg_zero;

  // Flags derived from the S1 operand sign bits and the adder sum.
  always_comb begin
    flg_cout = (s1_a_q[15] & s1_b_q[15]) | ((s1_a_q[15] ^ s1_b_q[15]) & ~add_sum[15]);
    flg_ovf  = (s1_a_q[15] == s1_b_q[15]) & (add_sum[15] != s1_a_q[15]);
    flg_zero = (add_sum == 16'h0000);
  end

  // Flags load into OR together with the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_cout_q <= 1'b0;
      or_ovf_q  <= 1'b0;
      or_zero_q <= 1'b0;
    end else if (s1_move) begin
      or_cout_q <= flg_cout;
      or_ovf_q  <= flg_ovf;
      or_zero_q <= flg_zero;
    end
  end

  assign out_cout = or_cout_q;
  assign out_ovf  = or_ovf_q;
  assign out_zero = or_zero_q;
`endif

endmodule
